multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencing FSM for the RV32I-subset datapath (lw, sw, addi/slli, add-class R-type, beq/bne/blt), sharing one ALU and one unified memory port across several cycles per instruction. It sits beside the datapath: it reads the instruction register and ALU flags, and drives the PC/IR write enables, the memory handshake, operand muxes, ALU op class and register write-back. It also keeps a retired-instruction counter and an illegal-opcode flag for debug.

## Interface
- No parameters.
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  current instruction register contents
- mem_ready  in  1  memory completes the current request this cycle
- alu_zero  in  1  ALU result == 0
- alu_lt  in  1  signed rs1 < rs2, from the ALU comparator
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req (sw)
- iord  out  1  0 = address from PC, 1 = address from ALU result register
- ir_write  out  1  load IR from memory data
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4 (ALU), 1 = branch target register
- alusrc_a  out  1  0 = PC, 1 = rs1
- alusrc_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- aluop  out  2  00 add, 01 compare/subtract, 10 R-type funct, 11 I-type funct
- imm_sel  out  2  00 I, 01 S, 10 B format for the immediate generator
- regwrite  out  1  register file write enable
- memtoreg  out  1  write-back source: 1 = memory data register
- illegal  out  1  sticky flag: unsupported opcode decoded
- retired  out  32  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH.
- IDLE: entered on reset. All outputs are 0. Moves to FETCH on the next edge.
- FETCH: mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, aluop=00. When mem_ready=1, assert ir_write=1 and pc_write=1 (pc_src=0) in that same cycle, then go to DECODE. If mem_ready=0, stay in FETCH with mem_req held.
- DECODE: alusrc_a=0, alusrc_b=10, imm_sel=10, aluop=00 to precompute the branch target. Next state by opcode = inst[6:0]:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 and 0100011 -> ADDR
  - 1100011 -> BRANCH
  - anything else -> set illegal, increment retired, go to FETCH
- EXEC_R: alusrc_a=1, alusrc_b=00, aluop=10 -> WB_ALU.
- EXEC_I: alusrc_a=1, alusrc_b=10, imm_sel=00, aluop=11 -> WB_ALU.
- ADDR: alusrc_a=1, alusrc_b=10, aluop=00. imm_sel=00 for lw, 01 for sw. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, iord=1. Waits on mem_ready, then goes to WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Waits on mem_ready, then retires and goes to FETCH.
- WB_MEM: regwrite=1, memtoreg=1; retires, then FETCH.
- WB_ALU: regwrite=1, memtoreg=0; retires, then FETCH.
- BRANCH: alusrc_a=1, alusrc_b=00, aluop=01, pc_src=1. pc_write is driven by f3 = inst[14:12]:
  - 000: pc_write = alu_zero
  - 001: pc_write = !alu_zero
  - 100: pc_write = alu_lt
  - other f3: pc_write=0
  - Always retires, then FETCH.
- Outputs are Moore decodes of state, except three that are combinationally qualified: ir_write/pc_write in FETCH (by mem_ready) and pc_write in BRANCH (by the flags).
- retired is a 32-bit register, +1 on every retire edge, wrapping 0xFFFFFFFF -> 0.
- illegal is sticky; only reset clears it.

## Timing
- Reset: state=IDLE, retired=0, illegal=0, all outputs 0. Asserting rst_n mid-instruction aborts it immediately: mem_req drops in the same cycle and no regwrite or pc_write occurs.
- Cycles per instruction with zero-wait memory (mem_ready=1 on the first request cycle):
  - R/I-type: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - illegal: 2
- Each memory wait cycle adds 1 to the count.
- Handshake: mem_req, mem_we and iord stay stable from request until the cycle mem_ready=1 is sampled. mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- retired updates on the edge that leaves the final state, so it is visible in the first FETCH cycle of the next instruction.

## Test plan
- Reset release, then add x1,x2,x3 with mem_ready tied 1: IDLE→FETCH→DECODE→EXEC_R→WB_ALU. regwrite=1 for exactly 1 cycle in cycle 5 after reset release; retired=1.
- lw with mem_ready low for 3 cycles in MEM_RD: mem_req and iord=1 held for 4 cycles, then WB_MEM with memtoreg=1; total 8 cycles.
- Branches:
  - beq with alu_zero=1: pc_write=1 and pc_src=1 in BRANCH.
  - bne with alu_zero=1: pc_write=0.
  - blt with alu_lt=1: pc_write=1.
  - f3=010: no pc_write.
- Opcode 0x7F: illegal rises after DECODE, retired increments, next FETCH follows; illegal stays 1 through subsequent valid instructions.
- rst_n pulsed low during MEM_WR: mem_req/mem_we fall immediately, state returns to IDLE, retired=0; preload retired near 0xFFFFFFFF via a long run to confirm wrap to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Sequencing FSM for a multi-cycle RV32I-subset datapath (lw, sw, addi/slli,
//   R-type add class, beq/bne/blt) that shares one ALU and one memory port.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     inst[31:0]            instruction register contents (opcode, funct3 used)
//     mem_ready             memory completes the outstanding request this cycle
//     alu_zero, alu_lt      ALU flags used by the branch decision
//     mem_req/mem_we/iord   memory request, write qualifier, address select
//     ir_write, pc_write    IR / PC load enables
//     pc_src                0 = PC+4 from ALU, 1 = branch target register
//     alusrc_a, alusrc_b    ALU operand selects
//     aluop, imm_sel        ALU op class, immediate format
//     regwrite, memtoreg    register write-back enable and source
//     illegal               sticky unsupported-opcode flag
//     retired[31:0]         completed-instruction counter (wraps)
//
//   state   | meaning
//   IDLE    | after reset, all outputs idle, one cycle
//   FETCH   | read instruction, PC <= PC+4 when memory answers
//   DECODE  | decode opcode, precompute branch target
//   EXEC_R  | rs1 op rs2
//   EXEC_I  | rs1 op imm
//   ADDR    | effective address for lw/sw
//   MEM_RD  | load data read
//   MEM_WR  | store data write, retires on completion
//   WB_MEM  | write load data to rd, retires
//   WB_ALU  | write ALU result to rd, retires
//   BRANCH  | compare, conditionally load branch target, retires
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_lt,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alusrc_a,
  output logic [1:0]  alusrc_b,
  output logic [1:0]  aluop,
  output logic [1:0]  imm_sel,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_MEM, S_WB_ALU, S_BRANCH
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        retire;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       unused_inst;

  assign opcode      = inst[6:0];
  assign f3          = inst[14:12];
  assign unused_inst = ^{inst[31:15], inst[11:7]};

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alusrc_a  = 1'b0;
    alusrc_b  = 2'b00;
    aluop     = 2'b00;
    imm_sel   = 2'b00;
    regwrite  = 1'b0;
    memtoreg  = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req  = 1'b1;
        alusrc_b = 2'b01;
        // IR and PC+4 are captured on the same edge the memory answers.
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        alusrc_b = 2'b10;
        imm_sel  = 2'b10;
        case (opcode)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default: begin
            illegal_d = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_EXEC_R: begin
        alusrc_a = 1'b1;
        aluop    = 2'b10;
        state_d  = S_WB_ALU;
      end

      S_EXEC_I: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
        aluop    = 2'b11;
        state_d  = S_WB_ALU;
      end

      S_ADDR: begin
        alusrc_a = 1'b1;
        alusrc_b = 2'b10;
        if (opcode == OP_STORE) begin
          imm_sel = 2'b01;
          state_d = S_MEM_WR;
        end else begin
          state_d = S_MEM_RD;
        end
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end

      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_WB_MEM: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_WB_ALU: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_BRANCH: begin
        alusrc_a = 1'b1;
        aluop    = 2'b01;
        pc_src   = 1'b1;
        case (f3)
          3'b000:  pc_write = alu_zero;
          3'b001:  pc_write = !alu_zero;
          3'b100:  pc_write = alu_lt;
          default: pc_write = 1'b0;
        endcase
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase

    retired_d = retire ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      retired_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Each scenario pushes the expected per-cycle
// control vector (plus the inputs to drive that cycle) onto a scoreboard
// queue; run_queue drives each entry and compares at the falling edge.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        mem_ready, alu_zero, alu_lt;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc_a;
  logic [1:0]  alusrc_b, aluop, imm_sel;
  logic        regwrite, memtoreg, illegal;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_retired = 32'd0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop), .imm_sel(imm_sel),
    .regwrite(regwrite), .memtoreg(memtoreg), .illegal(illegal), .retired(retired)
  );

  logic [14:0] obs;
  assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alusrc_a,
                alusrc_b, aluop, imm_sel, regwrite, memtoreg};

  typedef struct {
    logic [14:0] ctrl;
    logic        rdy;
    logic        zero;
    logic        lt;
    string       tag;
  } item_t;

  item_t sb[$];

  function automatic logic [14:0] ctl(input logic mreq, mwe, io, irw, pcw, pcs, a,
                                      input logic [1:0] b, op, imm,
                                      input logic rw, m2r);
    return {mreq, mwe, io, irw, pcw, pcs, a, b, op, imm, rw, m2r};
  endfunction

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] opc);
    return {17'd0, f3, 5'd1, opc};
  endfunction

  function automatic void push(input logic [14:0] c, input logic r, z, l, input string t);
    item_t it;
    it.ctrl = c; it.rdy = r; it.zero = z; it.lt = l; it.tag = t;
    sb.push_back(it);
  endfunction

  // Expected vectors per state
  function automatic logic [14:0] v_idle();   return 15'd0; endfunction
  function automatic logic [14:0] v_fetch(input logic r);
    return ctl(1, 0, 0, r, r, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
  endfunction
  function automatic logic [14:0] v_decode(); return ctl(0,0,0,0,0,0,0,2'b10,2'b00,2'b10,0,0); endfunction
  function automatic logic [14:0] v_exec_r(); return ctl(0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0); endfunction
  function automatic logic [14:0] v_exec_i(); return ctl(0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0,0); endfunction
  function automatic logic [14:0] v_addr(input logic is_sw);
    return ctl(0,0,0,0,0,0,1,2'b10,2'b00,is_sw ? 2'b01 : 2'b00,0,0);
  endfunction
  function automatic logic [14:0] v_mem_rd(); return ctl(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0); endfunction
  function automatic logic [14:0] v_mem_wr(); return ctl(1,1,1,0,0,0,0,2'b00,2'b00,2'b00,0,0); endfunction
  function automatic logic [14:0] v_wb_mem(); return ctl(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,1); endfunction
  function automatic logic [14:0] v_wb_alu(); return ctl(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0); endfunction
  function automatic logic [14:0] v_branch(input logic tk);
    return ctl(0,0,0,0,tk,1,1,2'b00,2'b01,2'b00,0,0);
  endfunction

  // Drives and checks every queued cycle; entered and left at posedge+1.
  task automatic run_queue();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.rdy;
      alu_zero  = it.zero;
      alu_lt    = it.lt;
      @(negedge clk);
      checks++;
      if (obs !== it.ctrl) begin
        failures++;
        $display("FAIL %s: ctrl got %b expected %b", it.tag, obs, it.ctrl);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_counters(input string t, input logic exp_ill);
    checks++;
    if (retired !== exp_retired) begin
      failures++;
      $display("FAIL %s retired: got %0d expected %0d", t, retired, exp_retired);
    end
    checks++;
    if (illegal !== exp_ill) begin
      failures++;
      $display("FAIL %s illegal: got %b expected %b", t, illegal, exp_ill);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inst = 32'd0; mem_ready = 1'b1; alu_zero = 1'b0; alu_lt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 0", obs);
    end
    check_counters("reset", 1'b0);
    rst_n = 1'b1;
  endtask

  // Starts in IDLE right after release: regwrite lands in the 5th cycle.
  task automatic test_r_type_after_reset();
    inst = mk_inst(3'b000, 7'b0110011);
    push(v_idle(),     1, 0, 0, "r_idle");
    push(v_fetch(1),   1, 0, 0, "r_fetch");
    push(v_decode(),   1, 1, 1, "r_decode");
    push(v_exec_r(),   1, 0, 1, "r_exec");
    push(v_wb_alu(),   1, 1, 0, "r_wb");
    run_queue();
    exp_retired++;
    check_counters("r_type", 1'b0);
  endtask

  task automatic test_addi();
    inst = mk_inst(3'b000, 7'b0010011);
    push(v_fetch(1), 1, 0, 0, "i_fetch");
    push(v_decode(), 0, 0, 0, "i_decode");
    push(v_exec_i(), 1, 0, 0, "i_exec");
    push(v_wb_alu(), 1, 0, 0, "i_wb");
    run_queue();
    exp_retired++;
    check_counters("addi", 1'b0);
  endtask

  task automatic test_lw_wait();
    inst = mk_inst(3'b010, 7'b0000011);
    push(v_fetch(1), 1, 0, 0, "lw_fetch");
    push(v_decode(), 1, 0, 0, "lw_decode");
    push(v_addr(0),  1, 0, 0, "lw_addr");
    for (int i = 0; i < 3; i++) push(v_mem_rd(), 0, 0, 0, "lw_mem_wait");
    push(v_mem_rd(), 1, 0, 0, "lw_mem_done");
    push(v_wb_mem(), 0, 0, 0, "lw_wb");
    run_queue();
    exp_retired++;
    check_counters("lw", 1'b0);
  endtask

  task automatic test_sw_fetch_wait();
    inst = mk_inst(3'b010, 7'b0100011);
    push(v_fetch(0), 0, 0, 0, "sw_fetch_wait");
    push(v_fetch(1), 1, 0, 0, "sw_fetch");
    push(v_decode(), 1, 0, 0, "sw_decode");
    push(v_addr(1),  1, 0, 0, "sw_addr");
    push(v_mem_wr(), 1, 0, 0, "sw_mem");
    run_queue();
    exp_retired++;
    check_counters("sw", 1'b0);
  endtask

  task automatic test_branches();
    logic [2:0] f3s[7]   = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b100, 3'b010};
    logic       zs[7]    = '{1, 0, 1, 0, 0, 1, 1};
    logic       lts[7]   = '{0, 1, 1, 0, 1, 0, 1};
    logic       taken[7] = '{1, 0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      inst = mk_inst(f3s[i], 7'b1100011);
      push(v_fetch(1),        1, 0, 0, $sformatf("br%0d_fetch", i));
      push(v_decode(),        1, 0, 0, $sformatf("br%0d_decode", i));
      push(v_branch(taken[i]), 1, zs[i], lts[i], $sformatf("br%0d_branch", i));
      run_queue();
      exp_retired++;
    end
    check_counters("branches", 1'b0);
  endtask

  task automatic test_illegal();
    inst = 32'h0000_007F;
    push(v_fetch(1), 1, 0, 0, "ill_fetch");
    push(v_decode(), 1, 0, 0, "ill_decode");
    run_queue();
    exp_retired++;
    check_counters("illegal_set", 1'b1);
    inst = mk_inst(3'b000, 7'b0110011);
    push(v_fetch(1), 1, 0, 0, "ill_next_fetch");
    push(v_decode(), 1, 0, 0, "ill_next_decode");
    push(v_exec_r(), 1, 0, 0, "ill_next_exec");
    push(v_wb_alu(), 1, 0, 0, "ill_next_wb");
    run_queue();
    exp_retired++;
    check_counters("illegal_sticky", 1'b1);
  endtask

  task automatic test_reset_mid_store();
    inst = mk_inst(3'b010, 7'b0100011);
    push(v_fetch(1), 1, 0, 0, "rst_fetch");
    push(v_decode(), 1, 0, 0, "rst_decode");
    push(v_addr(1),  1, 0, 0, "rst_addr");
    push(v_mem_wr(), 0, 0, 0, "rst_mem_wait");
    run_queue();
    // still in MEM_WR; hold ready high so a missed abort would show a retire
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_req: got %b expected 00", {mem_req, mem_we});
    end
    checks++;
    if (obs !== 15'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got %b expected 0", obs);
    end
    exp_retired = 32'd0;
    check_counters("rst_mid", 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    inst = mk_inst(3'b000, 7'b0010011);
    push(v_idle(),   1, 0, 0, "rst_rec_idle");
    push(v_fetch(1), 1, 0, 0, "rst_rec_fetch");
    push(v_decode(), 1, 0, 0, "rst_rec_decode");
    push(v_exec_i(), 1, 0, 0, "rst_rec_exec");
    push(v_wb_alu(), 1, 0, 0, "rst_rec_wb");
    run_queue();
    exp_retired++;
    check_counters("rst_recover", 1'b0);
  endtask

  initial begin
    test_reset();
    test_r_type_after_reset();
    test_addi();
    test_lw_wait();
    test_sw_fetch_wait();
    test_branches();
    test_illegal();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
